// File: rtl/sos_gen_module_if.sv
// Start/status bundle between the trigger-to-enable stage, the SOS generator and the buzzer.
interface sos_gen_module_if;
    logic SOS_En_Sig;
    logic Pin_Out;
    logic Busy_Sig;
    logic Done_Sig;

    modport master (output SOS_En_Sig, input Pin_Out, Busy_Sig, Done_Sig);
    modport slave  (input SOS_En_Sig, output Pin_Out, Busy_Sig, Done_Sig);
endinterface

// File: rtl/sos_gen_module.sv
// Plays one Morse "... --- ..." on Pin_Out per accepted start pulse, then pulses Done_Sig.
module sos_gen_module #(
    parameter int T_UNIT = 5_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    sos_gen_module_if.slave  bus
);
    localparam int CW = $clog2(3 * T_UNIT + 1);
    // Counter is loaded with duration-1 so a phase lasts exactly its nominal length.
    localparam logic [CW-1:0] ONE_LD   = CW'(T_UNIT - 1);
    localparam logic [CW-1:0] THREE_LD = CW'(3 * T_UNIT - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic          pin_q, busy_q, done_q;

    function automatic logic [CW-1:0] on_load(input logic [3:0] i);
        return (i >= 4'd3 && i <= 4'd5) ? THREE_LD : ONE_LD;
    endfunction

    function automatic logic [CW-1:0] gap_load(input logic [3:0] i);
        return (i == 4'd2 || i == 4'd5) ? THREE_LD : ONE_LD;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            pin_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.SOS_En_Sig) begin
                        idx    <= '0;
                        cnt    <= on_load(4'd0);
                        pin_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= ON;
                    end
                end
                ON: begin
                    if (cnt == '0) begin
                        pin_q <= 1'b0;
                        if (idx == 4'd8) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt   <= gap_load(idx);
                            state <= OFF;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OFF: begin
                    if (cnt == '0) begin
                        idx   <= 4'(idx + 1'b1);
                        cnt   <= on_load(4'(idx + 1'b1));
                        pin_q <= 1'b1;
                        state <= ON;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Pin_Out  = pin_q;
    assign bus.Busy_Sig = busy_q;
    assign bus.Done_Sig = done_q;
endmodule

// File: tb/tb_sos_gen_module.sv
// Three generators (T_UNIT = 4, 2, 1) driven side by side and scoreboarded against a unit-pattern model.
module tb_sos_gen_module;
    logic       clk;
    logic [2:0] rst, en;
    logic [2:0] pin, busy, done;

    typedef struct packed {
        logic [2:0] pin;
        logic [2:0] busy;
        logic [2:0] done;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   st[3] = '{-1, -1, -1};
    bit   pat[27];
    bit   fin   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sos_gen_module_if bus ();
        assign bus.SOS_En_Sig = en[g];
        assign pin[g]  = bus.Pin_Out;
        assign busy[g] = bus.Busy_Sig;
        assign done[g] = bus.Done_Sig;
        sos_gen_module #(.T_UNIT(4 >> g)) dut (.CLK(clk), .RST(rst[g]), .bus(bus));
    end

    // Morse unit pattern: ON units then gap units per element, no gap after the last.
    initial begin
        int p;
        p = 0;
        for (int e = 0; e < 9; e++) begin
            int on_u, gap_u;
            on_u  = (e >= 3 && e <= 5) ? 3 : 1;
            gap_u = (e == 8) ? 0 : ((e == 2 || e == 5) ? 3 : 1);
            for (int u = 0; u < on_u; u++) begin pat[p] = 1'b1; p++; end
            for (int u = 0; u < gap_u; u++) begin pat[p] = 1'b0; p++; end
        end
    end

    task automatic step(input logic [2:0] e, input logic [2:0] r);
        exp_t x;
        @(negedge clk);
        en  = e;
        rst = r;
        x   = '0;
        for (int i = 0; i < 3; i++) begin
            int tu, k;
            tu = 4 >> i;
            if (r[i]) st[i] = -1;
            else if (st[i] >= 0) begin
                k = cyc - st[i];
                if (k >= 1 && k <= 27 * tu) begin
                    x.busy[i] = 1'b1;
                    x.pin[i]  = pat[(k - 1) / tu];
                end
                if (k == 27 * tu + 1) x.done[i] = 1'b1;
            end
        end
        sbq.push_back(x);
        for (int i = 0; i < 3; i++)
            if (!r[i] && e[i] && (st[i] < 0 || cyc - st[i] >= 27 * (4 >> i) + 2))
                st[i] = cyc;
        cyc++;
    endtask

    // Monitor: checks each cycle's outputs mid-cycle, which also exposes asynchronous reset.
    always @(negedge clk) begin
        exp_t x;
        #1;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({pin[i], busy[i], done[i]} !== {x.pin[i], x.busy[i], x.done[i]}) begin
                    n_bad++;
                    $display("FAIL dut%0d cycle %0d pin/busy/done: got %b%b%b expected %b%b%b",
                             i, cyc - 1, pin[i], busy[i], done[i], x.pin[i], x.busy[i], x.done[i]);
                end
            end
        end
    end

    initial begin
        #200_000;
        if (!fin) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not complete, cycle %0d", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        rst = 3'b000;
        en  = 3'b000;
        #1 rst = 3'b111;
        en = 3'b111;

        // Reset held with start high, then released with start low.
        for (int t = 0; t < 3; t++) step(3'b111, 3'b111);
        #2;
        n_cmp++;
        if ({pin, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset state: pin=%b busy=%b done=%b expected all 0", pin, busy, done);
        end
        for (int t = 0; t < 5; t++) step(3'b000, 3'b000);

        // Single sequence; dut0 also gets retriggers while busy and one right at IDLE re-entry.
        for (int t = 0; t <= 240; t++) begin
            logic [2:0] e;
            e    = '0;
            e[0] = (t == 0 || t == 30 || t == 108 || t == 109 || t == 110);
            e[1] = (t == 0);
            e[2] = (t == 0);
            step(e, 3'b000);
        end

        // Start held high: back-to-back sequences, then drain.
        for (int t = 0; t < 150; t++) step(3'b111, 3'b000);
        for (int t = 0; t < 120; t++) step(3'b000, 3'b000);

        // Reset inside the first dash, restart 5 cycles after release.
        for (int t = 0; t <= 160; t++) begin
            logic [2:0] e, r;
            e = (t == 0 || t == 47) ? 3'b111 : 3'b000;
            r = (t == 40 || t == 41) ? 3'b111 : 3'b000;
            step(e, r);
        end

        // Random starts with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            logic [2:0] e, r;
            for (int i = 0; i < 3; i++) begin
                e[i] = ($urandom_range(0, 39) == 0);
                r[i] = ($urandom_range(0, 499) == 0);
            end
            step(e, r);
        end

        @(negedge clk);
        #3;
        fin = 1'b1;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard not drained: %0d entries left", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sos_gen_module.md
# sos_gen_module

Morse SOS pattern generator feeding the buzzer pin. It sits directly downstream of the trigger-to-enable stage and consumes its one-cycle `SOS_En_Sig` pulse. Each accepted pulse plays exactly one "... --- ..." sequence on `Pin_Out`, then pulses `Done_Sig`. Timing is built from a single parameterised time unit so the bench can run with a tiny unit.

## Interface
- `T_UNIT`, default 5_000_000: length of one Morse time unit in CLK cycles (100 ms at 50 MHz); legal range 1 .. 2^26.
- `CLK`  in  1  system clock, all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `SOS_En_Sig`  in  1  start request, one-cycle pulse from the upstream enable stage.
- `Pin_Out`  out  1  buzzer drive, 1 = sounding.
- `Busy_Sig`  out  1  high while a sequence is playing.
- `Done_Sig`  out  1  one-cycle pulse when a sequence has completed.

## Operation
- States: IDLE, ON, OFF, DONE.
- Element list, fixed, index 0..8: dot, dot, dot, dash, dash, dash, dot, dot, dot.
  - Dot ON time = 1 unit; dash ON time = 3 units.
  - OFF time after an element within a letter (index 0,1,3,4,6,7) = 1 unit.
  - OFF time after index 2 and 5 (letter gap) = 3 units.
  - No OFF phase after index 8.
- IDLE: if `SOS_En_Sig`=1, load index 0, load the ON duration into the cycle counter, go to ON.
- ON: `Pin_Out`=1. When the counter expires:
  - index < 8: go to OFF with the gap duration.
  - index = 8: go to DONE.
- OFF: `Pin_Out`=0. When the counter expires: increment index, load the next ON duration, go to ON.
- DONE: lasts one cycle, `Done_Sig`=1, then go to IDLE.
- `SOS_En_Sig` is ignored in ON, OFF and DONE; there is no queueing.
- All outputs are registered.
- Counter width is ceil(log2(3*T_UNIT+1)). The duration is computed as 3*T_UNIT without overflow.

## Timing
- Reset values: `Pin_Out`=0, `Busy_Sig`=0, `Done_Sig`=0, state IDLE, index 0, counter 0.
- Define cycle 0 as the cycle in which `SOS_En_Sig`=1 is sampled in IDLE.
- Latency: `Pin_Out` rises in cycle 1.
- Total sounding plus gap span is 27*T_UNIT cycles:
  - `Busy_Sig`=1 in cycles 1 .. 27*T_UNIT.
  - `Done_Sig`=1 in cycle 27*T_UNIT+1 only, with `Busy_Sig`=0 and `Pin_Out`=0 in that cycle.
  - IDLE is reached from cycle 27*T_UNIT+2. A new pulse sampled then starts a new sequence at the next cycle.
- Each ON or OFF phase lasts exactly its nominal unit count times T_UNIT cycles, with no extra transition cycle between phases.
- `RST` asserted mid-sequence: all outputs go to 0 immediately (asynchronously), and no `Done_Sig` is generated. After release the block is in IDLE and accepts the next pulse.
- `SOS_En_Sig` held high continuously: sequences repeat back-to-back, one per 27*T_UNIT+2 cycles.
- T_UNIT=1 is legal: dot = 1 cycle high.

## Test plan
- Reset check: hold `RST`=1 for 3 cycles with `SOS_En_Sig`=1 -> all outputs 0 throughout; after release with `SOS_En_Sig`=0, outputs stay 0.
- Full sequence, T_UNIT=4, one pulse at cycle 0:
  - `Pin_Out`=1 exactly in cycles 1-4, 9-12, 17-20, 33-44, 49-60, 65-76, 89-92, 97-100, 105-108, and 0 elsewhere.
  - `Busy_Sig`=1 in cycles 1-108.
  - `Done_Sig`=1 only in cycle 109.
- Retrigger while busy, T_UNIT=4: pulses at cycles 0, 30, 108 and 109 -> waveform identical to the full-sequence test. The first new `Pin_Out` rise after that occurs only if a pulse arrives at cycle ≥110.
- Back-to-back, T_UNIT=2, `SOS_En_Sig` held high -> second sequence `Pin_Out` rises at cycle 57.
  - First sequence: `Done_Sig` at cycle 55 (27*2+1).
  - Second sequence starts at sample cycle 56.
- Mid-sequence reset, T_UNIT=4: assert `RST` at cycle 40, inside the first dash -> `Pin_Out` and `Busy_Sig` drop to 0 at once, no `Done_Sig`. A pulse 5 cycles after release restarts from a dot: `Pin_Out` high for 4 cycles, then low for 4.
- Minimum unit, T_UNIT=1, one pulse -> `Pin_Out` pattern 1,0,1,0,1,0,0,0 then 1,1,1,0,1,1,1,0,1,1,1,0,0,0 then 1,0,1,0,1 starting at cycle 1; `Done_Sig` at cycle 28.
